// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART echo engine.
// Pure declarations; no timing or backpressure of its own.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_CRLF  = 2'd2,
        MODE_LINE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        GAP     = 2'd2,
        SEND_LF = 2'd3
    } state_t;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] LOWER_A    = 8'h61;
    localparam logic [7:0] LOWER_Z    = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= LOWER_A) && (c <= LOWER_Z);
    endfunction

endpackage

// File: rtl/uart_echo_fifo_if.sv
// Receive strobe, transmit handshake and status bundle of the echo engine.
// Master is the SoC/UART side; slave is the echo engine.
interface uart_echo_fifo_if #(
    parameter int Width = 8,
    parameter int AW    = 4
);
    logic [Width-1:0] RX_DATA;
    logic             RX_VALID;
    logic [Width-1:0] TX_DATA;
    logic             TX_OE;
    logic             TX_RDY;
    logic [1:0]       MODE;
    logic             CLR_OVR;
    logic             OVERRUN;
    logic [AW:0]      LEVEL;

    modport master (
        output RX_DATA, RX_VALID, TX_RDY, MODE, CLR_OVR,
        input  TX_DATA, TX_OE, OVERRUN, LEVEL
    );

    modport slave (
        input  RX_DATA, RX_VALID, TX_RDY, MODE, CLR_OVR,
        output TX_DATA, TX_OE, OVERRUN, LEVEL
    );
endinterface

// File: rtl/uart_echo_fifo_fifo.sv
// Power-of-two synchronous FIFO with first-word fall-through read data.
// Count updates one cycle after push/pop; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16,
    parameter int AW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo with uppercase, CR->CRLF and line-release modes, plus overrun/level status.
// First TX_OE two cycles after RX_VALID into an empty FIFO; pops only when TX_RDY is high, drops on full.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 16,
    parameter int AW    = $clog2(Depth)
) (
    input logic               CLK,
    input logic               RST,
    uart_echo_fifo_if.slave   bus
);
    localparam int WX = (Width > 8) ? Width : 8;
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [Width-1:0] pop_dat;
    logic [WX-1:0]    rx_ext, pop_ext;
    logic             full, empty;
    logic [AW:0]      level;
    logic             push, pop, drop, rx_cr, pop_cr, release_ok;
    mode_t            mode_in;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic             lf_q, lf_d;
    logic [Width-1:0] tx_data_q, tx_data_d;
    logic             tx_oe_q, tx_oe_d;
    logic             ovr_q, ovr_d;
    logic [AW:0]      lcnt_q, lcnt_d;
    logic             flush_q, flush_d;
    logic [Width-1:0] xform;

    sync_fifo #(.Width(Width), .Depth(Depth), .AW(AW)) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_dat (bus.RX_DATA),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty),
        .count    (level)
    );

    // Character-aware modes only exist for byte-wide words.
    assign mode_in    = (Width == 8) ? mode_t'(bus.MODE) : MODE_ECHO;
    assign rx_ext     = WX'(bus.RX_DATA);
    assign pop_ext    = WX'(pop_dat);
    assign rx_cr      = (Width == 8) && (rx_ext == WX'(CHAR_CR));
    assign pop_cr     = (Width == 8) && (pop_ext == WX'(CHAR_CR));
    assign release_ok = (mode_in != MODE_LINE) || (lcnt_q != '0) || flush_q;
    assign pop        = (state_q == IDLE) && !empty && bus.TX_RDY && release_ok;
    assign push       = bus.RX_VALID && (!full || pop);
    assign drop       = bus.RX_VALID && !push;

    always_comb begin
        xform = pop_dat;
        if (mode_in == MODE_UPPER && is_lower(pop_ext[7:0]))
            xform = Width'(pop_ext[7:0] - CASE_DELTA);
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lf_d      = lf_q;
        tx_data_d = tx_data_q;
        tx_oe_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    mode_d    = mode_in;
                    tx_data_d = xform;
                    tx_oe_d   = 1'b1;
                    lf_d      = (mode_in == MODE_CRLF) && pop_cr;
                    state_d   = SEND;
                end
            end
            SEND:    state_d = GAP;
            GAP:     state_d = (mode_q == MODE_CRLF && lf_q) ? SEND_LF : IDLE;
            SEND_LF: begin
                if (bus.TX_RDY) begin
                    tx_data_d = Width'(CHAR_LF);
                    tx_oe_d   = 1'b1;
                    lf_d      = 1'b0;
                    state_d   = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (drop)             ovr_d = 1'b1;
        else if (bus.CLR_OVR) ovr_d = 1'b0;

        lcnt_d = lcnt_q;
        if ((push && rx_cr) && !(pop && pop_cr))      lcnt_d = lcnt_q + CNT_ONE;
        else if (!(push && rx_cr) && (pop && pop_cr)) lcnt_d = lcnt_q - CNT_ONE;

        // A full FIFO with no complete line would deadlock line mode; drain it all.
        flush_d = flush_q;
        if (empty)
            flush_d = 1'b0;
        else if (full && lcnt_q == '0 && mode_in == MODE_LINE)
            flush_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            mode_q    <= MODE_ECHO;
            lf_q      <= 1'b0;
            tx_data_q <= '0;
            tx_oe_q   <= 1'b0;
            ovr_q     <= 1'b0;
            lcnt_q    <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lf_q      <= lf_d;
            tx_data_q <= tx_data_d;
            tx_oe_q   <= tx_oe_d;
            ovr_q     <= ovr_d;
            lcnt_q    <= lcnt_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.TX_DATA = tx_data_q;
    assign bus.TX_OE   = tx_oe_q;
    assign bus.OVERRUN = ovr_q;
    assign bus.LEVEL   = level;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: expected TX words queued at stimulus time, compared on TX_OE.
module tb_uart_echo_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tx_cnt = 0;
    int   last_tx = 0;
    int   base;
    logic [7:0] exp_q[$];

    uart_echo_fifo_if #(.Width(8), .AW(4)) bus ();

    uart_echo_fifo #(.Width(8), .Depth(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.TX_OE) begin
            if (exp_q.size() == 0) chk("tx_extra_qsize", 32'(exp_q.size()), 32'd1);
            else                   chk("tx_data", 32'(bus.TX_DATA), 32'(exp_q.pop_front()));
            if (tx_cnt > 0) chk("oe_gap", 32'((cyc - last_tx) >= 2), 32'd1);
            last_tx = cyc;
            tx_cnt++;
        end
    end

    task automatic push(input logic [7:0] w);
        bus.RX_DATA  = w;
        bus.RX_VALID = 1'b1;
        @(posedge clk); #1;
        bus.RX_VALID = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX_DATA = '0; bus.RX_VALID = 1'b0; bus.TX_RDY = 1'b1;
        bus.MODE = 2'd0; bus.CLR_OVR = 1'b0;
        step(3);
        chk("rst_tx_oe",   32'(bus.TX_OE),   32'd0);
        chk("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        chk("rst_overrun", 32'(bus.OVERRUN), 32'd0);
        chk("rst_level",   32'(bus.LEVEL),   32'd0);
        rst = 1'b0;
        step(2);

        // Mode 0 latency
        exp_q.push_back(8'h41);
        push(8'h41);
        chk("m0_level1", 32'(bus.LEVEL), 32'd1);
        chk("m0_oe_early", 32'(bus.TX_OE), 32'd0);
        step(1);
        chk("m0_oe", 32'(bus.TX_OE), 32'd1);
        chk("m0_data", 32'(bus.TX_DATA), 32'h41);
        chk("m0_level0", 32'(bus.LEVEL), 32'd0);
        drain(50);

        // Mode 1 uppercase
        bus.MODE = 2'd1;
        base = tx_cnt;
        foreach (exp_q[i]) exp_q.delete(i);
        begin
            logic [7:0] s [3] = '{8'h61, 8'h5A, 8'h7B};
            for (int i = 0; i < 3; i++) exp_q.push_back(upper(s[i]));
            for (int i = 0; i < 3; i++) push(s[i]);
        end
        drain(100);
        chk("m1_count", 32'(tx_cnt - base), 32'd3);

        // Mode 2 CRLF with stalled transmitter
        bus.MODE = 2'd2;
        base = tx_cnt;
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); exp_q.push_back(8'h31);
        push(8'h0D);
        push(8'h31);
        bus.TX_RDY = 1'b0;
        step(50);
        chk("m2_stall_cnt", 32'(tx_cnt - base), 32'd1);
        chk("m2_stall_level", 32'(bus.LEVEL), 32'd1);
        bus.TX_RDY = 1'b1;
        drain(100);
        chk("m2_count", 32'(tx_cnt - base), 32'd3);

        // Mode 3 line release
        bus.MODE = 2'd3;
        base = tx_cnt;
        exp_q.push_back(8'h68); exp_q.push_back(8'h69); exp_q.push_back(8'h0D);
        push(8'h68);
        push(8'h69);
        step(100);
        chk("m3_hold_cnt", 32'(tx_cnt - base), 32'd0);
        chk("m3_hold_level", 32'(bus.LEVEL), 32'd2);
        push(8'h0D);
        drain(100);
        chk("m3_count", 32'(tx_cnt - base), 32'd3);
        chk("m3_level", 32'(bus.LEVEL), 32'd0);

        // Overrun with stalled transmitter
        bus.MODE = 2'd0;
        bus.TX_RDY = 1'b0;
        base = tx_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(8'h30 + i));
            push(8'(8'h30 + i));
        end
        chk("ovr_level", 32'(bus.LEVEL), 32'd16);
        chk("ovr_set", 32'(bus.OVERRUN), 32'd1);
        bus.CLR_OVR = 1'b1; step(1); bus.CLR_OVR = 1'b0;
        chk("ovr_clr", 32'(bus.OVERRUN), 32'd0);
        bus.CLR_OVR = 1'b1;
        push(8'h99);
        bus.CLR_OVR = 1'b0;
        chk("ovr_set_wins", 32'(bus.OVERRUN), 32'd1);
        bus.CLR_OVR = 1'b1; step(1); bus.CLR_OVR = 1'b0;
        chk("ovr_clr2", 32'(bus.OVERRUN), 32'd0);
        bus.TX_RDY = 1'b1;
        drain(200);
        chk("ovr_out_cnt", 32'(tx_cnt - base), 32'd16);

        // Mode 3 flush on full FIFO
        bus.MODE = 2'd3;
        base = tx_cnt;
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        drain(200);
        chk("flush_cnt", 32'(tx_cnt - base), 32'd16);
        chk("flush_level", 32'(bus.LEVEL), 32'd0);
        base = tx_cnt;
        exp_q.push_back(8'h41); exp_q.push_back(8'h0D);
        push(8'h41);
        step(20);
        chk("flush_cleared", 32'(tx_cnt - base), 32'd0);
        push(8'h0D);
        drain(100);

        // Reset while waiting in SEND_LF
        bus.MODE = 2'd2;
        base = tx_cnt;
        exp_q.push_back(8'h0D);
        push(8'h0D);
        push(8'h42);
        bus.TX_RDY = 1'b0;
        step(5);
        chk("lf_wait_cnt", 32'(tx_cnt - base), 32'd1);
        chk("lf_wait_level", 32'(bus.LEVEL), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_oe", 32'(bus.TX_OE), 32'd0);
        chk("rst_mid_level", 32'(bus.LEVEL), 32'd0);
        step(2);
        rst = 1'b0;
        bus.TX_RDY = 1'b1;
        step(30);
        chk("rst_no_lf", 32'(tx_cnt - base), 32'd1);
        chk("rst_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rst_level_after", 32'(bus.LEVEL), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
